// File: rtl/rec_play_slots.sv
// rec_play_slots: multi-slot record/playback controller for the voice path.
// The external SRAM is split into NUM_SLOTS equal slots. Each slot keeps its
// own recorded length, so several clips can be stored and replayed
// independently. The SRAM is read asynchronously: the address is held
// registered, and read data is captured on the cycle of a player request.
module rec_play_slots #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int NUM_SLOTS = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_init_done,
    input  logic                                  i_key_rec,
    input  logic                                  i_key_play,
    input  logic                                  i_key_stop,
    input  logic [$clog2(NUM_SLOTS)-1:0]          i_slot_sel,
    input  logic                                  i_loop,
    input  logic                                  i_rec_valid,
    input  logic [DATA_W-1:0]                     i_rec_data,
    input  logic                                  i_play_req,
    input  logic [DATA_W-1:0]                     i_sram_rdata,
    output logic [ADDR_W-1:0]                     o_sram_addr,
    output logic [DATA_W-1:0]                     o_sram_wdata,
    output logic                                  o_sram_we,
    output logic [DATA_W-1:0]                     o_play_data,
    output logic                                  o_play_valid,
    output logic [2:0]                            o_state,
    output logic [$clog2(NUM_SLOTS)-1:0]          o_cur_slot,
    output logic [ADDR_W-$clog2(NUM_SLOTS):0]     o_ptr,
    output logic [ADDR_W-$clog2(NUM_SLOTS):0]     o_len,
    output logic                                  o_full,
    output logic                                  o_done,
    output logic                                  o_err
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = ADDR_W - SLOT_W;
    localparam logic [PTR_W:0] SLOT_SIZE = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READY      = 3'd1,
        S_REC        = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   cur_slot;
    logic [PTR_W:0]      ptr;
    logic [PTR_W:0]      len_tab [NUM_SLOTS];
    logic [PTR_W:0]      ptr_inc;
    logic [PTR_W:0]      cur_len;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic                sram_we;
    logic [DATA_W-1:0]   play_data;
    logic                play_valid;
    logic                full;
    logic                done;
    logic                err;

    assign ptr_inc = ptr + PTR_ONE;
    assign cur_len = len_tab[cur_slot];

    // Single controller: mode FSM, slot pointer, length table and SRAM/player outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cur_slot   <= '0;
            ptr        <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            play_data  <= '0;
            play_valid <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_tab[i] <= '0;
            end
        end else begin
            sram_we    <= 1'b0;
            play_valid <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_init_done) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (i_key_stop) begin
                        state <= S_READY;
                    end else if (i_key_rec) begin
                        cur_slot  <= i_slot_sel;
                        ptr       <= '0;
                        sram_addr <= {i_slot_sel, {PTR_W{1'b0}}};
                        state     <= S_REC;
                    end else if (i_key_play) begin
                        cur_slot <= i_slot_sel;
                        ptr      <= '0;
                        if (len_tab[i_slot_sel] == '0) begin
                            err <= 1'b1;
                        end else begin
                            sram_addr <= {i_slot_sel, {PTR_W{1'b0}}};
                            state     <= S_PLAY;
                        end
                    end
                end
                S_REC: begin
                    if (i_key_stop) begin
                        len_tab[cur_slot] <= ptr;
                        state             <= S_READY;
                    end else if (i_key_rec) begin
                        state <= S_REC_PAUSE;
                    end else if (i_rec_valid) begin
                        sram_we    <= 1'b1;
                        sram_addr  <= {cur_slot, ptr[PTR_W-1:0]};
                        sram_wdata <= i_rec_data;
                        ptr        <= ptr_inc;
                        if (ptr_inc == SLOT_SIZE) begin
                            len_tab[cur_slot] <= SLOT_SIZE;
                            full              <= 1'b1;
                            state             <= S_READY;
                        end
                    end
                end
                S_REC_PAUSE: begin
                    if (i_key_stop) begin
                        len_tab[cur_slot] <= ptr;
                        state             <= S_READY;
                    end else if (i_key_rec) begin
                        state <= S_REC;
                    end
                end
                S_PLAY: begin
                    if (i_key_stop) begin
                        state <= S_READY;
                    end else if (i_key_play) begin
                        state <= S_PLAY_PAUSE;
                    end else if (i_play_req) begin
                        play_data  <= i_sram_rdata;
                        play_valid <= 1'b1;
                        if (ptr_inc == cur_len) begin
                            done <= 1'b1;
                            if (i_loop) begin
                                ptr       <= '0;
                                sram_addr <= {cur_slot, {PTR_W{1'b0}}};
                            end else begin
                                ptr       <= ptr_inc;
                                sram_addr <= {cur_slot, ptr_inc[PTR_W-1:0]};
                                state     <= S_READY;
                            end
                        end else begin
                            ptr       <= ptr_inc;
                            sram_addr <= {cur_slot, ptr_inc[PTR_W-1:0]};
                        end
                    end
                end
                S_PLAY_PAUSE: begin
                    if (i_key_stop) begin
                        state <= S_READY;
                    end else if (i_key_play) begin
                        state <= S_PLAY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sram_addr  = sram_addr;
    assign o_sram_wdata = sram_wdata;
    assign o_sram_we    = sram_we;
    assign o_play_data  = play_data;
    assign o_play_valid = play_valid;
    assign o_state      = state;
    assign o_cur_slot   = cur_slot;
    assign o_ptr        = ptr;
    assign o_len        = cur_len;
    assign o_full       = full;
    assign o_done       = done;
    assign o_err        = err;

endmodule

// File: tb/tb_rec_play_slots.sv
// Bench for rec_play_slots. Two instances share one stimulus stream: a small
// one (6-bit address, 16-word slots) followed every cycle by a clip-level
// model, and a full-size one (20-bit address) pinned by literal expectations.
module tb_rec_play_slots;

    localparam int SS = 16;
    localparam int ST_IDLE = 0, ST_READY = 1, ST_REC = 2, ST_REC_PAUSE = 3;
    localparam int ST_PLAY = 4, ST_PLAY_PAUSE = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_init_done = 1'b0;
    logic        i_key_rec = 1'b0;
    logic        i_key_play = 1'b0;
    logic        i_key_stop = 1'b0;
    logic [1:0]  i_slot_sel = '0;
    logic        i_loop = 1'b0;
    logic        i_rec_valid = 1'b0;
    logic [15:0] i_rec_data = '0;
    logic        i_play_req = 1'b0;

    logic [15:0] s_rdata, s_wdata, s_play_data;
    logic [5:0]  s_addr;
    logic        s_we, s_play_valid, s_full, s_done, s_err;
    logic [2:0]  s_state;
    logic [1:0]  s_cur_slot;
    logic [4:0]  s_ptr, s_len;

    logic [15:0] b_rdata, b_wdata, b_play_data;
    logic [19:0] b_addr;
    logic        b_we, b_play_valid, b_full, b_done, b_err;
    logic [2:0]  b_state;
    logic [1:0]  b_cur_slot;
    logic [18:0] b_ptr, b_len;

    logic [15:0] mem_s [0:63];
    logic [15:0] mem_b [0:(1<<20)-1];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int m_state, m_slot, m_ptr;
    int m_len [4];
    int m_samp [4][SS];
    int e_addr, e_wdata, e_play_data;
    bit e_we, e_play_valid, e_full, e_done, e_err;

    rec_play_slots #(.ADDR_W(6), .DATA_W(16), .NUM_SLOTS(4)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_init_done(i_init_done),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
        .i_slot_sel(i_slot_sel), .i_loop(i_loop), .i_rec_valid(i_rec_valid),
        .i_rec_data(i_rec_data), .i_play_req(i_play_req), .i_sram_rdata(s_rdata),
        .o_sram_addr(s_addr), .o_sram_wdata(s_wdata), .o_sram_we(s_we),
        .o_play_data(s_play_data), .o_play_valid(s_play_valid), .o_state(s_state),
        .o_cur_slot(s_cur_slot), .o_ptr(s_ptr), .o_len(s_len),
        .o_full(s_full), .o_done(s_done), .o_err(s_err)
    );

    rec_play_slots #(.ADDR_W(20), .DATA_W(16), .NUM_SLOTS(4)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_init_done(i_init_done),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
        .i_slot_sel(i_slot_sel), .i_loop(i_loop), .i_rec_valid(i_rec_valid),
        .i_rec_data(i_rec_data), .i_play_req(i_play_req), .i_sram_rdata(b_rdata),
        .o_sram_addr(b_addr), .o_sram_wdata(b_wdata), .o_sram_we(b_we),
        .o_play_data(b_play_data), .o_play_valid(b_play_valid), .o_state(b_state),
        .o_cur_slot(b_cur_slot), .o_ptr(b_ptr), .o_len(b_len),
        .o_full(b_full), .o_done(b_done), .o_err(b_err)
    );

    always #5 i_clk = ~i_clk;

    // SRAM models: write on the clock edge, asynchronous read
    always @(posedge i_clk) begin
        if (s_we) mem_s[s_addr] <= s_wdata;
        if (b_we) mem_b[b_addr] <= b_wdata;
    end
    assign s_rdata = mem_s[s_addr];
    assign b_rdata = mem_b[b_addr];

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Clip-level model of the small instance: per-slot sample lists and lengths
    task automatic model_step();
        e_we = 1'b0; e_play_valid = 1'b0; e_full = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (i_rst) begin
            m_state = ST_IDLE; m_slot = 0; m_ptr = 0;
            e_addr = 0; e_wdata = 0; e_play_data = 0;
            for (int i = 0; i < 4; i++) m_len[i] = 0;
            return;
        end
        case (m_state)
            ST_IDLE: if (i_init_done) m_state = ST_READY;
            ST_READY: begin
                if (i_key_stop) begin
                end else if (i_key_rec) begin
                    m_slot = int'(i_slot_sel); m_ptr = 0; e_addr = m_slot * SS;
                    m_state = ST_REC;
                end else if (i_key_play) begin
                    m_slot = int'(i_slot_sel); m_ptr = 0;
                    if (m_len[m_slot] == 0) e_err = 1'b1;
                    else begin
                        e_addr = m_slot * SS; m_state = ST_PLAY;
                    end
                end
            end
            ST_REC, ST_REC_PAUSE: begin
                if (i_key_stop) begin
                    m_len[m_slot] = m_ptr; m_state = ST_READY;
                end else if (i_key_rec) begin
                    m_state = (m_state == ST_REC) ? ST_REC_PAUSE : ST_REC;
                end else if (m_state == ST_REC && i_rec_valid) begin
                    m_samp[m_slot][m_ptr] = int'(i_rec_data);
                    e_we = 1'b1; e_addr = m_slot * SS + m_ptr; e_wdata = int'(i_rec_data);
                    m_ptr++;
                    if (m_ptr == SS) begin
                        m_len[m_slot] = SS; e_full = 1'b1; m_state = ST_READY;
                    end
                end
            end
            ST_PLAY, ST_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    m_state = ST_READY;
                end else if (i_key_play) begin
                    m_state = (m_state == ST_PLAY) ? ST_PLAY_PAUSE : ST_PLAY;
                end else if (m_state == ST_PLAY && i_play_req) begin
                    e_play_data = m_samp[m_slot][m_ptr]; e_play_valid = 1'b1;
                    m_ptr++;
                    if (m_ptr == m_len[m_slot]) begin
                        e_done = 1'b1;
                        if (i_loop) m_ptr = 0;
                        else m_state = ST_READY;
                    end
                    e_addr = m_slot * SS + (m_ptr % SS);
                end
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            model_step();
        end
    end

    // Every-cycle comparison of the small instance against the model
    always @(negedge i_clk) begin
        if (check_en) begin
            check_output("state", s_state, m_state);
            check_output("cur_slot", s_cur_slot, m_slot);
            check_output("ptr", s_ptr, m_ptr);
            check_output("len", s_len, m_len[m_slot]);
            check_output("sram_we", s_we, e_we);
            check_output("sram_wdata", s_wdata, e_wdata);
            check_output("play_valid", s_play_valid, e_play_valid);
            check_output("play_data", s_play_data, e_play_data);
            check_output("full", s_full, e_full);
            check_output("done", s_done, e_done);
            check_output("err", s_err, e_err);
            if (e_we || m_state == ST_PLAY) check_output("sram_addr", s_addr, e_addr);
        end
    end

    task automatic apply_stimulus();
        @(posedge i_clk);
        #1;
        i_key_rec = 1'b0; i_key_play = 1'b0; i_key_stop = 1'b0;
        i_rec_valid = 1'b0; i_play_req = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_b_state"}, b_state, 0);
        check_output({tag, "_b_addr"}, b_addr, 0);
        check_output({tag, "_b_len"}, b_len, 0);
        check_output({tag, "_b_ptr"}, b_ptr, 0);
        check_output({tag, "_b_play_data"}, b_play_data, 0);
        check_output({tag, "_b_we"}, b_we, 0);
        check_output({tag, "_s_addr"}, s_addr, 0);
        check_output({tag, "_s_wdata"}, s_wdata, 0);
    endtask

    initial begin
        int done_cnt;
        int r;
        // reset and leave IDLE
        apply_stimulus();
        check_en = 1'b1;
        apply_stimulus();
        check_reset_state("reset");
        i_rst = 1'b0; i_init_done = 1'b1;
        apply_stimulus();
        check_output("b_ready", b_state, 1);

        // record five samples into slot 2
        i_slot_sel = 2'd2; i_key_rec = 1'b1;
        apply_stimulus();
        check_output("b_rec_state", b_state, 2);
        for (int i = 0; i < 5; i++) begin
            i_rec_valid = 1'b1; i_rec_data = 16'h0011 + 16'(i);
            apply_stimulus();
            check_output("b_wr_we", b_we, 1);
            check_output("b_wr_addr", b_addr, 20'h80000 + i);
            check_output("b_wr_data", b_wdata, 16'h0011 + i);
            check_output("b_wr_ptr", b_ptr, i + 1);
            check_output("s_wr_addr", s_addr, 6'h20 + i);
            apply_stimulus();
        end
        i_key_stop = 1'b1;
        apply_stimulus();
        check_output("b_stop_state", b_state, 1);
        check_output("b_len5", b_len, 5);

        // play slot 2 once through
        i_loop = 1'b0; i_key_play = 1'b1;
        apply_stimulus();
        check_output("b_play_state", b_state, 4);
        for (int i = 0; i < 5; i++) begin
            i_play_req = 1'b1;
            apply_stimulus();
            check_output("b_play_valid", b_play_valid, 1);
            check_output("b_play_data", b_play_data, 16'h0011 + i);
            if (i == 4) begin
                check_output("b_done", b_done, 1);
                check_output("b_end_state", b_state, 1);
            end
            apply_stimulus();
        end
        i_play_req = 1'b1;
        apply_stimulus();
        check_output("b_extra_req_valid", b_play_valid, 0);
        apply_stimulus();

        // looped playback
        i_loop = 1'b1; i_key_play = 1'b1;
        apply_stimulus();
        done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            i_play_req = 1'b1;
            apply_stimulus();
            check_output("b_loop_data", b_play_data, 16'h0011 + (i % 5));
            done_cnt += int'(b_done);
            apply_stimulus();
        end
        check_output("b_loop_done_count", done_cnt, 1);
        check_output("b_loop_state", b_state, 4);
        i_key_stop = 1'b1; i_loop = 1'b0;
        apply_stimulus();

        // empty slot, simultaneous keys
        i_slot_sel = 2'd0; i_key_play = 1'b1;
        apply_stimulus();
        check_output("b_empty_err", b_err, 1);
        check_output("b_empty_state", b_state, 1);
        i_slot_sel = 2'd1; i_key_rec = 1'b1; i_key_play = 1'b1;
        apply_stimulus();
        check_output("b_rec_wins", b_state, 2);
        i_key_stop = 1'b1;
        apply_stimulus();

        // fill a slot of the small instance
        i_slot_sel = 2'd3; i_key_rec = 1'b1;
        apply_stimulus();
        for (int i = 0; i < 16; i++) begin
            i_rec_valid = 1'b1; i_rec_data = 16'h0100 + 16'(i);
            apply_stimulus();
            if (i == 15) begin
                check_output("s_full", s_full, 1);
                check_output("s_full_state", s_state, 1);
                check_output("s_full_len", s_len, 16);
                check_output("s_full_addr", s_addr, 6'h3F);
            end
            apply_stimulus();
        end
        i_rec_valid = 1'b1; i_rec_data = 16'h0200;
        apply_stimulus();
        check_output("s_17th_we", s_we, 0);
        check_output("b_17th_addr", b_addr, 20'hC0010);
        apply_stimulus();
        i_key_stop = 1'b1;
        apply_stimulus();
        check_output("b_len17", b_len, 17);

        // pause during record
        i_slot_sel = 2'd0; i_key_rec = 1'b1;
        apply_stimulus();
        i_rec_valid = 1'b1; i_rec_data = 16'h00A0;
        apply_stimulus();
        apply_stimulus();
        i_key_rec = 1'b1;
        apply_stimulus();
        check_output("b_pause_state", b_state, 3);
        for (int i = 0; i < 3; i++) begin
            i_rec_valid = 1'b1; i_rec_data = 16'h0BAD;
            apply_stimulus();
            check_output("b_pause_we", b_we, 0);
            apply_stimulus();
        end
        i_key_rec = 1'b1;
        apply_stimulus();
        i_rec_valid = 1'b1; i_rec_data = 16'h00A1;
        apply_stimulus();
        check_output("b_resume_addr", b_addr, 20'h00001);
        check_output("b_resume_we", b_we, 1);
        check_output("b_resume_ptr", b_ptr, 2);
        apply_stimulus();

        // reset mid-record discards everything
        i_rst = 1'b1;
        apply_stimulus();
        check_reset_state("midrec");
        i_rst = 1'b0;
        apply_stimulus();
        i_slot_sel = 2'd2; i_key_play = 1'b1;
        apply_stimulus();
        check_output("b_after_reset_err", b_err, 1);
        check_output("b_after_reset_state", b_state, 1);

        // randomized traffic, checked by the model on the small instance
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            i_slot_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) i_loop = ~i_loop;
            if ($urandom_range(0, 599) == 0) i_rst = 1'b1;
            if (r < 4) i_key_rec = 1'b1;
            else if (r < 9) i_key_play = 1'b1;
            else if (r < 11) i_key_stop = 1'b1;
            else if (r < 12) begin
                i_key_rec = 1'b1; i_key_play = 1'b1;
            end else if (r < 50) begin
                i_rec_valid = 1'b1; i_rec_data = 16'($urandom);
            end else if (r < 85) i_play_req = 1'b1;
            apply_stimulus();
            i_rst = 1'b0;
            apply_stimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rec_play_slots.md
# rec_play_slots

Multi-slot record/playback controller for the voice path: successor to the single-buffer record/play FSM. It partitions the external SRAM into `NUM_SLOTS` equal slots, each with its own stored length. It accepts sample strobes from the recorder side and read requests from the player/DSP side. It drives the SRAM address, data and write-enable, and adds auto-stop on full, end-of-clip detection, loop playback and empty-slot rejection.

## Interface
- `ADDR_W`, 20: SRAM word-address width.
- `DATA_W`, 16: sample/SRAM data width.
- `NUM_SLOTS`, 4: number of slots; power of two, ≥2.
- Derived: `SLOT_W` = log2(`NUM_SLOTS`); `PTR_W` = `ADDR_W`−`SLOT_W`; `SLOT_SIZE` = 2^`PTR_W`.

Ports:
- `i_clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_init_done` in 1: codec initialisation finished (level).
- `i_key_rec` in 1: record / record-pause toggle, one-cycle pulse.
- `i_key_play` in 1: play / play-pause toggle, one-cycle pulse.
- `i_key_stop` in 1: stop, one-cycle pulse.
- `i_slot_sel` in `SLOT_W`: slot chosen for the next record/play.
- `i_loop` in 1: loop playback enable (level, sampled at end of clip).
- `i_rec_valid` in 1: one captured sample on `i_rec_data`.
- `i_rec_data` in `DATA_W`: sample to store.
- `i_play_req` in 1: player requests next sample.
- `i_sram_rdata` in `DATA_W`: SRAM read data (asynchronous read).
- `o_sram_addr` out `ADDR_W`: {slot, ptr}, registered.
- `o_sram_wdata` out `DATA_W`: write data, registered.
- `o_sram_we` out 1: active-high write strobe, one cycle per sample.
- `o_play_data` out `DATA_W`: fetched sample.
- `o_play_valid` out 1: `o_play_data` valid, one cycle.
- `o_state` out 3: FSM state encoding below.
- `o_cur_slot` out `SLOT_W`: slot latched at the last record/play start.
- `o_ptr` out `PTR_W`+1: current in-slot pointer.
- `o_len` out `PTR_W`+1: stored length of `o_cur_slot`.
- `o_full`, `o_done`, `o_err` out 1: one-cycle event pulses.

## Operation
- States: IDLE=0, READY=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5.
- IDLE→READY when `i_init_done`=1. All keys are ignored in IDLE.
- READY, `i_key_rec`: latch `i_slot_sel`, ptr←0, go to REC.
- READY, `i_key_play`: latch slot, ptr←0. If that slot's length is 0, pulse `o_err` and stay in READY; otherwise go to PLAY.
- READY, `i_key_rec` and `i_key_play` in the same cycle: record wins.
- REC, `i_key_rec` → REC_PAUSE. REC_PAUSE, `i_key_rec` → REC. Same pattern for PLAY/PLAY_PAUSE with `i_key_play`. Pause holds ptr.
- In any non-IDLE state, `i_key_stop` has priority over every other key that cycle.
- Stop from REC or REC_PAUSE: len[slot]←ptr, go to READY.
- Stop from PLAY or PLAY_PAUSE: go to READY; lengths unchanged.
- `i_slot_sel` is used only when recording or playback starts.
- REC and `i_rec_valid`: write sample at {slot, ptr}, ptr←ptr+1.
  - If the new ptr = `SLOT_SIZE`: len[slot]←`SLOT_SIZE`, pulse `o_full`, go to READY. Further `i_rec_valid` is ignored.
- PLAY and `i_play_req`: capture `i_sram_rdata` at {slot, ptr} into `o_play_data`, ptr←ptr+1.
  - If the new ptr = len[slot]: if `i_loop`=1, ptr←0 and stay in PLAY; otherwise pulse `o_done` and go to READY. `o_done` pulses on every clip end, looping or not.
- `i_rec_valid` outside REC and `i_play_req` outside PLAY are ignored.
- Length table: `NUM_SLOTS` × (`PTR_W`+1) registers. Re-recording a slot overwrites its length on stop/full. Other slots are untouched.
- `o_sram_we` is only ever 1 in REC.

## Timing
- Reset: state=IDLE. All outputs 0, including `o_sram_addr`, `o_sram_wdata`, `o_sram_we`, `o_play_data`, `o_play_valid`, `o_cur_slot`, `o_ptr`, `o_len` and all pulses. All slot lengths ←0.
- Reset mid-record discards the take (length 0).
- Key response: the state changes on the edge after the key cycle.
- Write latency: `i_rec_valid` at cycle N gives `o_sram_we`=1 at N+1, with `o_sram_addr`={slot, ptr_old} and `o_sram_wdata`=sample. `o_ptr` shows ptr_old+1 at N+1.
- Read: `o_sram_addr` holds {slot, ptr} while idle in PLAY. `i_play_req` at N gives `o_play_valid`=1 with data at N+1, and the address advances at N+1.
- `i_play_req` and `i_rec_valid` must be at least 2 cycles apart. The address must settle before the next read.
- `o_full`, `o_done` and `o_err` assert in the cycle the state is updated and last exactly 1 cycle.

## Test plan
- Reset, `i_init_done`=1, rec on slot 2, 5 `i_rec_valid` with data 0x0011..0x0015, stop → writes at addresses 0x80000..0x80004 (`ADDR_W`=20, 4 slots), len[2]=5, state READY.
- Play slot 2, `i_loop`=0, 5 requests → `o_play_data` = 0x0011..0x0015, `o_done` pulse on the 5th, state READY. A 6th request yields no `o_play_valid`.
- Play slot 2 with `i_loop`=1, 7 requests → data 11,12,13,14,15,11,12; one `o_done` pulse; state remains PLAY.
- `PTR_W` reduced (`ADDR_W`=6, 4 slots): record 16 samples → `o_full` on the 16th, len=16, state READY. A 17th valid produces no write.
- Play on empty slot 0 → `o_err` pulse, state READY. `i_key_rec` with `i_key_play` in READY → REC.
- Pause in REC, 3 valids (no writes), resume, 1 valid → write at ptr continuing. Assert `i_rst` mid-REC → all zero, lengths 0.
